// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding and default geometry.
package mem_arb_pkg;

    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MEM_DEPTH = 201;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector; on a tie the port that did not win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    assign grant_valid = req0 | req1;
    assign grant_idx   = req1 & (~req0 | ~last_grant);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch (port 0) and data (port 1) accesses onto one single-port memory.
// state   | meaning
// IDLE    | waiting for a request; winner's operands latched on the granting edge
// ACCESS  | memory driven for one cycle; read data captured / write committed at its end
// RESP    | one-cycle ack (and err) to the granted port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state;
    logic              last_grant;
    logic              gnt_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              pick_valid;
    logic              pick_idx;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_oob;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    always_comb begin
        win_we    = we0;
        win_addr  = addr0;
        win_wdata = wdata0;
        if (pick_idx) begin
            win_we    = we1;
            win_addr  = addr1;
            win_wdata = wdata1;
        end
    end

    // Range is judged once at grant time; zero-extended so no address can wrap into range.
    assign win_oob = (32'(win_addr) >= 32'(MEM_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= pick_idx;
                        last_grant <= pick_idx;
                        we_q       <= win_we;
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        err_q      <= win_oob;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        if (gnt_q) rdata1 <= err_q ? '0 : mem_read_data;
                        else       rdata0 <= err_q ? '0 : mem_read_data;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = (state == ST_ACCESS) || (state == ST_RESP);
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read       = (state == ST_ACCESS) && !we_q && !err_q;
    assign mem_write      = (state == ST_ACCESS) &&  we_q && !err_q;
    assign ack0           = (state == ST_RESP) && !gnt_q;
    assign ack1           = (state == ST_RESP) &&  gnt_q;
    assign err0           = ack0 && err_q;
    assign err1           = ack1 && err_q;

endmodule
